dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer for the word-addressed data memory. Port 0 is the CPU load/store path; port 1 is the loader/DMA path. The block sits between both requesters and the single data-memory port (address, data, out, memread, memwrite). It serialises accesses with round-robin fairness, range- and alignment-checks addresses, and returns read data and a one-cycle ack per transaction.

Parameters:
SIZE, 64, number of 32-bit words in the data memory; legal byte addresses are 0 .. 4*SIZE-4.
AW, 32, address width in bits.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
req0  input  1  port 0 request; held high until ack0.
we0  input  1  port 0 write enable (1 = store, 0 = load); stable while req0.
addr0  input  AW  port 0 byte address; stable while req0.
wdata0  input  32  port 0 store data; stable while req0.
ack0  output  1  port 0 transaction complete; one-cycle pulse.
err0  output  1  port 0 error; valid with ack0.
rdata0  output  32  port 0 load data; valid with ack0, held until the next port 0 ack.
req1, we1, addr1, wdata1, ack1, err1, rdata1: identical set for port 1.
mem_address  output  AW  to memory address.
mem_data  output  32  to memory write data.
mem_memread  output  1  to memory memread.
mem_memwrite  output  1  to memory memwrite; memory commits on negedge clk.
mem_out  input  32  from memory read data (combinational in address).

Behaviour:
- Reset (async): state=IDLE; last_grant=1, so port 0 wins the first tie. All outputs 0: ack*, err*, rdata*, mem_*.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: no req -> stay. Single req -> grant it. Both req -> grant the port != last_grant. On grant, latch sel, we, addr, wdata into internal regs. Compute bad = (addr[1:0]!=0) or (addr>>2 >= SIZE), then go to ACCESS.
- ACCESS, one cycle: mem_address=latched addr, mem_data=latched wdata.
  - Not bad: mem_memread=~we; mem_memwrite=we.
  - Bad: both mem strobes 0.
  - At the posedge ending ACCESS, capture rdata_q = (read and not bad) ? mem_out : 0, then go to RESP.
  - The write commits at the negedge inside ACCESS, while the latched regs are stable.
- RESP, one cycle: ack[sel]=1, err[sel]=bad. rdata[sel] is updated from rdata_q and holds afterwards. last_grant=sel. Go to IDLE. The unselected port's outputs are unchanged.
- mem_* outputs are 0 in IDLE and RESP. mem_memwrite is never high outside ACCESS.
- Transaction latency: req sampled in IDLE -> ack 2 cycles later (3-cycle occupancy). Max throughput is one transaction per 3 cycles.
- Requester rules:
  - The requester may drop req in the cycle after ack, or keep it high to request again.
  - A req still high in RESP is not a new grant in that cycle; it is re-arbitrated in the following IDLE.
  - Round-robin alternates strictly under continuous dual requests.
- Request changes after grant are ignored; the latched copies are used.
- A store with err=1 leaves memory untouched. A load with err=1 returns 0.
- Reset mid-ACCESS: mem_memwrite drops immediately (async). If reset precedes the negedge, the write is suppressed. No ack is issued and the transaction is lost.
- Reset mid-RESP: ack drops immediately, and rdata* clears to 0.

Test Plan:
- Port 0 store: addr0=0x10, wdata0=0xDEADBEEF. Then port 0 load of 0x10. -> First ack0 at cycle+2 with err0=0. Second ack0 with rdata0=0xDEADBEEF. mem_memwrite high exactly one cycle.
- Simultaneous req0 and req1 loads from reset, both held for 4 transactions. -> Grant order 0,1,0,1. Acks 3 cycles apart. No cycle with ack0 and ack1 both high.
- Port 1 store 0x12345678 to addr 0x100 (word 64 = SIZE). -> ack1 with err1=1, mem_memwrite never asserted. A load of 0x100 returns rdata1=0, err1=1.
- Misaligned port 0 load addr0=0x06. -> err0=1, rdata0=0, mem_memread stays 0.
- Port 1 store 0xA5A5A5A5 to 0x20 with reset asserted in ACCESS before negedge clk. -> No ack1, outputs 0. A subsequent load of 0x20 returns the prior value (0 after init).
- req0 held continuously while req1 idles. -> ack0 every 3 cycles. Later asserting req1 gets granted at the next IDLE after the current port 0 ack.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// dmem_arbiter_if: both requester ports plus the single data-memory port.
// Rev 1.0
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
    parameter int AW = 32
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [31:0]   wdata0;
    logic          ack0;
    logic          err0;
    logic [31:0]   rdata0;

    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [31:0]   wdata1;
    logic          ack1;
    logic          err1;
    logic [31:0]   rdata1;

    logic [AW-1:0] mem_address;
    logic [31:0]   mem_data;
    logic          mem_memread;
    logic          mem_memwrite;
    logic [31:0]   mem_out;

    // Arbiter side: requests come in, acks and memory strobes go out.
    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_out,
        output ack0, err0, rdata0,
        output ack1, err1, rdata1,
        output mem_address, mem_data, mem_memread, mem_memwrite
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_out,
        input  ack0, err0, rdata0,
        input  ack1, err1, rdata1,
        input  mem_address, mem_data, mem_memread, mem_memwrite
    );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter: round-robin two-port arbiter/sequencer for word data memory.
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int SIZE = 64,
    parameter int AW   = 32
) (
    input  wire logic     clk,
    input  wire logic     reset,
    dmem_arbiter_if.slave bus
);
    localparam logic [AW-1:0] c_SIZE = AW'(SIZE);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic          r_last;
    logic          r_sel;
    logic          r_we;
    logic          r_bad;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata0;
    logic [31:0]   r_rdata1;

    logic          w_grant;
    logic          w_sel;
    logic          w_sel_we;
    logic [AW-1:0] w_sel_addr;
    logic [31:0]   w_sel_wdata;
    logic          w_bad;
    logic [31:0]   w_rd;

    logic          w_ack0;
    logic          w_ack1;
    logic [AW-1:0] w_mem_address;
    logic [31:0]   w_mem_data;
    logic          w_mem_memread;
    logic          w_mem_memwrite;

    // On a tie the port that did not win last time is chosen.
    assign w_sel       = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
    assign w_sel_we    = w_sel ? bus.we1    : bus.we0;
    assign w_sel_addr  = w_sel ? bus.addr1  : bus.addr0;
    assign w_sel_wdata = w_sel ? bus.wdata1 : bus.wdata0;
    assign w_bad       = (w_sel_addr[1:0] != 2'b00) || ((w_sel_addr >> 2) >= c_SIZE);
    assign w_rd        = (!r_we && !r_bad) ? bus.mem_out : 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_grant        = 1'b0;
        w_ack0         = 1'b0;
        w_ack1         = 1'b0;
        w_mem_address  = '0;
        w_mem_data     = 32'd0;
        w_mem_memread  = 1'b0;
        w_mem_memwrite = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    w_grant = 1'b1;
                    w_next  = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_mem_address  = r_addr;
                w_mem_data     = r_wdata;
                w_mem_memread  = !r_we && !r_bad;
                w_mem_memwrite = r_we && !r_bad;
                w_next         = S_RESP;
            end
            S_RESP: begin
                w_ack0 = !r_sel;
                w_ack1 = r_sel;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last   <= 1'b1;
            r_sel    <= 1'b0;
            r_we     <= 1'b0;
            r_bad    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_rdata0 <= 32'd0;
            r_rdata1 <= 32'd0;
        end else begin
            if (w_grant) begin
                r_sel   <= w_sel;
                r_we    <= w_sel_we;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_bad   <= w_bad;
            end
            // Read data lands in the selected port's register so it is
            // already valid in the ack cycle and holds until that port's next ack.
            if (r_state == S_ACCESS) begin
                if (r_sel) begin
                    r_rdata1 <= w_rd;
                end else begin
                    r_rdata0 <= w_rd;
                end
            end
            if (r_state == S_RESP) begin
                r_last <= r_sel;
            end
        end
    end

    assign bus.ack0         = w_ack0;
    assign bus.ack1         = w_ack1;
    assign bus.err0         = w_ack0 && r_bad;
    assign bus.err1         = w_ack1 && r_bad;
    assign bus.rdata0       = r_rdata0;
    assign bus.rdata1       = r_rdata1;
    assign bus.mem_address  = w_mem_address;
    assign bus.mem_data     = w_mem_data;
    assign bus.mem_memread  = w_mem_memread;
    assign bus.mem_memwrite = w_mem_memwrite;
endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// tb_dmem_arbiter: directed stimulus against a transaction-level model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;
    logic clk;
    logic reset;

    dmem_arbiter_if #(.AW(32)) dif ();

    dmem_arbiter #(.SIZE(64), .AW(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical memory: reads combinational, writes on negedge.
    logic [31:0] tbmem [64];
    assign dif.mem_out = (dif.mem_address[31:2] < 30'd64) ? tbmem[dif.mem_address[7:2]] : 32'hBAD0BAD0;
    always @(negedge clk) begin
        if (dif.mem_memwrite) tbmem[dif.mem_address[7:2]] <= dif.mem_data;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a grant decided in cycle k is accessed in
    // k+1, acked in k+2, and the next grant may be decided in k+3.
    logic [31:0] mmem [64];
    int          cyc = 0;
    int          free_cyc = 0;
    int          t_acc = 0;
    bit          pend = 1'b0;
    bit          lg = 1'b1;
    bit          t_p, t_we, t_bad;
    logic [31:0] t_addr, t_wd, t_res;
    logic [31:0] hold0 = 32'd0;
    logic [31:0] hold1 = 32'd0;
    int          wr_cycles = 0;
    int          ack_port[$];
    int          ack_cyc[$];

    always @(negedge clk) begin
        logic        e_ack0, e_ack1, e_err0, e_err1, e_rd, e_wr;
        logic [31:0] e_ma, e_md;
        cyc++;
        e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0; e_rd = 0; e_wr = 0;
        e_ma = 32'd0; e_md = 32'd0;
        if (reset) begin
            pend = 1'b0; lg = 1'b1; hold0 = 32'd0; hold1 = 32'd0; free_cyc = cyc + 1;
        end else if (pend) begin
            if (cyc == t_acc) begin
                e_ma = t_addr; e_md = t_wd;
                e_rd = !t_we && !t_bad;
                e_wr = t_we && !t_bad;
                if (e_wr) mmem[t_addr[7:2]] = t_wd;
                t_res = e_rd ? mmem[t_addr[7:2]] : 32'd0;
            end else if (cyc == t_acc + 1) begin
                if (t_p) begin e_ack1 = 1; e_err1 = t_bad; hold1 = t_res; end
                else     begin e_ack0 = 1; e_err0 = t_bad; hold0 = t_res; end
                lg = t_p;
                pend = 1'b0;
            end
        end
        check("ack0",     32'(dif.ack0), 32'(e_ack0));
        check("ack1",     32'(dif.ack1), 32'(e_ack1));
        check("err0",     32'(dif.err0), 32'(e_err0));
        check("err1",     32'(dif.err1), 32'(e_err1));
        check("rdata0",   dif.rdata0, hold0);
        check("rdata1",   dif.rdata1, hold1);
        check("mem_addr", dif.mem_address, e_ma);
        check("mem_data", dif.mem_data, e_md);
        check("memread",  32'(dif.mem_memread), 32'(e_rd));
        check("memwrite", 32'(dif.mem_memwrite), 32'(e_wr));
        check("ack_excl", 32'(dif.ack0 & dif.ack1), 32'd0);
        if (dif.mem_memwrite) wr_cycles++;
        if (dif.ack0) begin ack_port.push_back(0); ack_cyc.push_back(cyc); end
        if (dif.ack1) begin ack_port.push_back(1); ack_cyc.push_back(cyc); end
        if (!reset && !pend && cyc >= free_cyc && (dif.req0 || dif.req1)) begin
            t_p    = (dif.req0 && dif.req1) ? !lg : dif.req1;
            t_we   = t_p ? dif.we1 : dif.we0;
            t_addr = t_p ? dif.addr1 : dif.addr0;
            t_wd   = t_p ? dif.wdata1 : dif.wdata0;
            t_bad  = (t_addr[1:0] != 2'b00) || (t_addr[31:2] >= 30'd64);
            t_acc  = cyc + 1;
            free_cyc = cyc + 3;
            pend   = 1'b1;
        end
    end

    task automatic txn(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
        bit got = 1'b0;
        @(posedge clk); #1;
        if (p) begin dif.req1 = 1; dif.we1 = we; dif.addr1 = a; dif.wdata1 = d; end
        else   begin dif.req0 = 1; dif.we0 = we; dif.addr0 = a; dif.wdata0 = d; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = p ? dif.ack1 : dif.ack0;
        end
        check("txn_ack_seen", 32'(got), 32'd1);
        rd = p ? dif.rdata1 : dif.rdata0;
        er = p ? dif.err1 : dif.err0;
        @(posedge clk); #1;
        if (p) dif.req1 = 0; else dif.req0 = 0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1; reset = 1;
        repeat (2) @(posedge clk);
        #1; reset = 0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          base, n, wr0;
        bit          to;
        for (int i = 0; i < 64; i++) begin tbmem[i] = 32'd0; mmem[i] = 32'd0; end
        reset = 1;
        dif.req0 = 0; dif.we0 = 0; dif.addr0 = 0; dif.wdata0 = 0;
        dif.req1 = 0; dif.we1 = 0; dif.addr1 = 0; dif.wdata1 = 0;
        repeat (3) @(posedge clk);
        #1; reset = 0;

        // Port 0 store then load back.
        wr0 = wr_cycles;
        txn(0, 1, 32'h10, 32'hDEADBEEF, rd, er);
        check("st0_err", 32'(er), 32'd0);
        txn(0, 0, 32'h10, 32'h0, rd, er);
        check("ld0_data", rd, 32'hDEADBEEF);
        check("ld0_err", 32'(er), 32'd0);
        check("st0_wr_cycles", 32'(wr_cycles - wr0), 32'd1);

        // Dual continuous requests from reset alternate 0,1,0,1.
        pulse_reset();
        base = ack_port.size();
        @(posedge clk); #1;
        dif.we0 = 0; dif.addr0 = 32'h10; dif.we1 = 0; dif.addr1 = 32'h14;
        dif.req0 = 1; dif.req1 = 1;
        n = 0; to = 1;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            n += int'(dif.ack0) + int'(dif.ack1);
            if (n >= 4) to = 0;
        end
        check("dual_timeout", 32'(to), 32'd0);
        @(posedge clk); #1; dif.req0 = 0; dif.req1 = 0;
        repeat (2) @(posedge clk);
        check("dual_nacks", 32'(ack_port.size() - base), 32'd4);
        if (ack_port.size() >= base + 4) begin
            for (int i = 0; i < 4; i++) check("dual_order", 32'(ack_port[base+i]), 32'(i % 2));
            for (int i = 1; i < 4; i++) check("dual_spacing", 32'(ack_cyc[base+i] - ack_cyc[base+i-1]), 32'd3);
        end
        check("dual_rdata0", dif.rdata0, 32'hDEADBEEF);

        // Out-of-range port 1 store and load.
        wr0 = wr_cycles;
        txn(1, 1, 32'h100, 32'h12345678, rd, er);
        check("oor_st_err", 32'(er), 32'd1);
        check("oor_st_nowrite", 32'(wr_cycles - wr0), 32'd0);
        txn(1, 0, 32'h100, 32'h0, rd, er);
        check("oor_ld_err", 32'(er), 32'd1);
        check("oor_ld_data", rd, 32'd0);

        // Misaligned port 0 load.
        txn(0, 0, 32'h06, 32'h0, rd, er);
        check("mis_err", 32'(er), 32'd1);
        check("mis_data", rd, 32'd0);

        // Reset during a port 1 store's access cycle, before the negedge.
        @(posedge clk); #1;
        dif.req1 = 1; dif.we1 = 1; dif.addr1 = 32'h20; dif.wdata1 = 32'hA5A5A5A5;
        @(posedge clk); #1;
        reset = 1; dif.req1 = 0;
        @(negedge clk);
        check("rst_memwrite", 32'(dif.mem_memwrite), 32'd0);
        check("rst_ack1", 32'(dif.ack1), 32'd0);
        check("rst_rdata0", dif.rdata0, 32'd0);
        repeat (2) @(posedge clk);
        #1; reset = 0;
        txn(1, 0, 32'h20, 32'h0, rd, er);
        check("rst_ld_data", rd, 32'd0);
        check("rst_ld_err", 32'(er), 32'd0);

        // Port 0 streams; port 1 joins mid-transaction and wins next IDLE.
        base = ack_port.size();
        @(posedge clk); #1;
        dif.we0 = 0; dif.addr0 = 32'h10; dif.req0 = 1;
        n = 0;
        for (int i = 0; i < 30 && n < 2; i++) begin
            @(negedge clk);
            n += int'(dif.ack0);
        end
        @(posedge clk);
        @(posedge clk); #1;
        dif.we1 = 0; dif.addr1 = 32'h14; dif.req1 = 1;
        to = 1;
        for (int i = 0; i < 30 && to; i++) begin
            @(negedge clk);
            if (dif.ack1) to = 0;
        end
        check("join_timeout", 32'(to), 32'd0);
        @(posedge clk); #1; dif.req0 = 0; dif.req1 = 0;
        repeat (2) @(posedge clk);
        check("join_nacks", 32'(ack_port.size() - base), 32'd4);
        if (ack_port.size() >= base + 4) begin
            check("join_p0a", 32'(ack_port[base]), 32'd0);
            check("join_p0b", 32'(ack_port[base+1]), 32'd0);
            check("join_p0c", 32'(ack_port[base+2]), 32'd0);
            check("join_p1",  32'(ack_port[base+3]), 32'd1);
            check("join_gap", 32'(ack_cyc[base+1] - ack_cyc[base]), 32'd3);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire
